// File: rtl/qos_fpga_pkg.sv
// Shared definitions for the FPGA front-end control path.
// Holds the mode encoding, the LED error pattern and the controller state enum.
package qos_fpga_pkg;

  localparam int unsigned MODE_W = 4;

  localparam logic [MODE_W-1:0] MODE_GOLDEN    = 4'd0;
  localparam logic [MODE_W-1:0] MODE_QSIM      = 4'd14;
  localparam logic [MODE_W-1:0] MODE_ROUNDTRIP = 4'd15;

  localparam int unsigned LED_W = 8;
  localparam logic [LED_W-1:0] LED_ERROR = '1;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_SHOW  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, level debounce, press pulse.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   i_btn_n      : raw active-low button, asynchronous to clk
//   o_press_evt  : registered one-cycle pulse on a debounced press (1->0)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press_evt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Counter measures how long the synchronized level has disagreed with stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn_n;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      // Edge detect on the delayed copy so the pulse trails the stable change by one cycle.
      r_press    <= r_stable_d & ~r_stable;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press_evt = r_press;

endmodule

// File: rtl/button_mode_ctrl.sv
// Front-end control: debounced mode stepping plus start/done handshake with the core.
// Ports:
//   WF_CLK, rst_n  : 12 MHz clock, async active-low reset
//   WF_BUTTON      : raw active-low pushbutton
//   mode           : current mode index to the core (stable from START through RUN)
//   core_start     : one-cycle start pulse
//   core_done      : one-cycle completion pulse, core_result valid with it
//   WF_LED         : latched result, or all ones on watchdog timeout
//   busy           : high while starting or running the core
module button_mode_ctrl
  import qos_fpga_pkg::*;
#(
  parameter int unsigned       DEBOUNCE_CYCLES = 20,
  parameter logic [MODE_W-1:0] RESET_MODE      = MODE_QSIM,
  parameter int unsigned       AUTOSTART_DELAY = 20,
  parameter int unsigned       TIMEOUT_CYCLES  = 4096,
  parameter int unsigned       RESULT_W        = LED_W
) (
  input  logic                WF_CLK,
  input  logic                rst_n,
  input  logic                WF_BUTTON,
  output logic [MODE_W-1:0]   mode,
  output logic                core_start,
  input  logic                core_done,
  input  logic [RESULT_W-1:0] core_result,
  output logic [RESULT_W-1:0] WF_LED,
  output logic                busy
);

  localparam int unsigned WAIT_W = $clog2(AUTOSTART_DELAY + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  ctrl_state_e         r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WD_W-1:0]     r_wd;
  logic [MODE_W-1:0]   r_mode;
  logic [RESULT_W-1:0] r_led;
  logic                r_start;
  logic                r_busy;
  logic                r_pending;
  logic                w_press_evt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (WF_CLK),
    .rst_n      (rst_n),
    .i_btn_n    (WF_BUTTON),
    .o_press_evt(w_press_evt)
  );

  // Controller FSM; all outputs are registered alongside the state.
  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT;
      r_wait_cnt <= '0;
      r_wd       <= '0;
      r_mode     <= RESET_MODE;
      r_led      <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (w_press_evt) r_pending <= 1'b1;
          // A pending press never shortens the autostart delay.
          if (r_wait_cnt == WAIT_W'(AUTOSTART_DELAY - 1)) begin
            r_state <= ST_START;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_START: begin
          if (w_press_evt) r_pending <= 1'b1;
          r_wd    <= WD_W'(TIMEOUT_CYCLES - 1);
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_press_evt) r_pending <= 1'b1;
          // Completion takes priority over a coincident watchdog expiry.
          if (core_done) begin
            r_led   <= core_result;
            r_state <= ST_SHOW;
            r_busy  <= 1'b0;
          end else if (r_wd == '0) begin
            r_led   <= '1;
            r_state <= ST_SHOW;
            r_busy  <= 1'b0;
          end else begin
            r_wd <= r_wd - WD_W'(1);
          end
        end
        ST_SHOW: begin
          if (w_press_evt || r_pending) begin
            r_mode    <= r_mode + MODE_W'(1);
            r_pending <= 1'b0;
            r_state   <= ST_START;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_WAIT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mode       = r_mode;
  assign core_start = r_start;
  assign WF_LED     = r_led;
  assign busy       = r_busy;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Self-checking bench for button_mode_ctrl: directed scenarios plus a randomized
// phase, all compared every cycle against a timestamp-based behavioural model.
module tb_button_mode_ctrl;
  import qos_fpga_pkg::*;

  localparam int D    = 20;
  localparam int AUTO = 20;
  localparam int TMO  = 4096;

  localparam int PH_WAIT  = 0;
  localparam int PH_START = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_SHOW  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              btn = 1'b1;
  logic              core_done = 1'b0;
  logic [LED_W-1:0]  core_result = '0;
  logic [MODE_W-1:0] mode;
  logic              core_start;
  logic [LED_W-1:0]  led;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int n_starts = 0;
  int n_mode_chg = 0;
  bit prev_busy = 0;
  logic [MODE_W-1:0] prev_mode = '0;

  button_mode_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RESET_MODE     (MODE_QSIM),
    .AUTOSTART_DELAY(AUTO),
    .TIMEOUT_CYCLES (TMO),
    .RESULT_W       (LED_W)
  ) dut (
    .WF_CLK     (clk),
    .rst_n      (rst_n),
    .WF_BUTTON  (btn),
    .mode       (mode),
    .core_start (core_start),
    .core_done  (core_done),
    .core_result(core_result),
    .WF_LED     (led),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit               m_hist[$];
  bit               m_stable, m_f1, m_f2, m_pend;
  int               m_phase, m_edges, m_run_from;
  logic [MODE_W-1:0] m_mode;
  logic [LED_W-1:0]  m_led;
  logic              m_start, m_busy;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < D + 2; i++) m_hist.push_back(1'b1);
    m_stable = 1; m_f1 = 0; m_f2 = 0; m_pend = 0;
    m_phase = PH_WAIT; m_edges = 0; m_run_from = 0;
    m_mode = MODE_QSIM; m_led = '0; m_start = 0; m_busy = 0;
  endtask

  task automatic model_step();
    bit press;
    bit flip;
    // Press seen by the controller stems from a debounced fall two edges ago.
    press = m_f2;
    m_hist.push_front(bit'(btn));
    void'(m_hist.pop_back());
    // Level accepted when the last D synchronized samples all disagree with stable.
    flip = 1;
    for (int i = 2; i < D + 2; i++) if (m_hist[i] == m_stable) flip = 0;
    m_f2 = m_f1;
    m_f1 = flip && m_stable;
    if (flip) m_stable = !m_stable;
    m_edges++;
    case (m_phase)
      PH_WAIT: begin
        if (press) m_pend = 1;
        if (m_edges == AUTO) m_phase = PH_START;
      end
      PH_START: begin
        if (press) m_pend = 1;
        m_phase = PH_RUN;
        m_run_from = m_edges;
      end
      PH_RUN: begin
        if (press) m_pend = 1;
        if (core_done === 1'b1) begin
          m_led = core_result; m_phase = PH_SHOW;
        end else if (m_edges - m_run_from == TMO) begin
          m_led = LED_ERROR; m_phase = PH_SHOW;
        end
      end
      default: begin
        if (press || m_pend) begin
          m_mode = MODE_W'((int'(m_mode) + 1) % 16);
          m_pend = 0;
          m_phase = PH_START;
        end
      end
    endcase
    m_start = (m_phase == PH_START);
    m_busy  = (m_phase == PH_START) || (m_phase == PH_RUN);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mode",       32'(mode),       32'(m_mode));
      check("core_start", 32'(core_start), 32'(m_start));
      check("WF_LED",     32'(led),        32'(m_led));
      check("busy",       32'(busy),       32'(m_busy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
    if (core_start === 1'b1) n_starts++;
    if (busy === 1'b1 && prev_busy && mode !== prev_mode) n_mode_chg++;
    prev_busy = (busy === 1'b1);
    prev_mode = mode;
  endtask

  task automatic wait_start(input int budget, output int k);
    k = 0;
    while (core_start !== 1'b1 && k < budget) begin step(); k++; end
    if (core_start !== 1'b1) check("start_wait_timeout", 32'(0), 32'(1));
  endtask

  task automatic press_to_start(input int hold, output int k, output int spent);
    btn = 1'b0;
    wait_start(80, k);
    spent = 0;
    while (k + spent < hold) begin step(); spent++; end
    btn = 1'b1;
  endtask

  task automatic core_finish(input int spent, input int lat, input logic [LED_W-1:0] val);
    repeat (lat - spent) step();
    core_result = val;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    core_result = LED_W'($urandom);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k, spent, s0, lat, done_in, btn_left;
    logic [LED_W-1:0] val;

    // Reset and autostart
    repeat (3) step();
    rst_n = 1'b1;
    chk_en = 1;
    wait_start(40, k);
    check("first_start_edge", 32'(k), 32'd20);
    check("first_start_mode", 32'(mode), 32'(MODE_QSIM));
    core_finish(0, 64, 8'hA5);
    check("first_led", 32'(led), 32'hA5);
    check("first_busy", 32'(busy), 32'd0);
    check("model_first_led", 32'(m_led), 32'hA5);
    repeat (30) step();

    // Press in SHOW: 14 -> 15, then wrap 15 -> 0
    press_to_start(30, k, spent);
    check("press_latency", 32'(k), 32'd24);
    check("mode_after_press", 32'(mode), 32'(MODE_ROUNDTRIP));
    val = LED_W'($urandom);
    core_finish(spent, int'($urandom_range(10, 120)), val);
    check("led_second_run", 32'(led), 32'(val));
    repeat (30) step();
    press_to_start(30, k, spent);
    check("press_latency_wrap", 32'(k), 32'd24);
    check("mode_wrap", 32'(mode), 32'(MODE_GOLDEN));
    check("model_mode_wrap", 32'(m_mode), 32'd0);
    core_finish(spent, int'($urandom_range(10, 120)), LED_W'($urandom));
    repeat (30) step();

    // Glitches and bouncing produce no event
    s0 = n_starts;
    for (int g = 0; g < 4; g++) begin
      btn = 1'b0;
      repeat ((g == 0) ? 15 : int'($urandom_range(1, D - 1))) step();
      btn = 1'b1;
      repeat (30) step();
    end
    for (int b = 0; b < 10; b++) begin
      btn = 1'b0; repeat (5) step();
      btn = 1'b1; repeat (5) step();
    end
    repeat (40) step();
    check("glitch_no_start", 32'(n_starts - s0), 32'd0);
    check("glitch_mode", 32'(mode), 32'(MODE_GOLDEN));
    check("glitch_busy", 32'(busy), 32'd0);

    // Two presses during a 500-cycle run collapse into one restart
    press_to_start(25, k, spent);
    check("mode_run1", 32'(mode), 32'd1);
    repeat (30) step(); spent += 30;
    btn = 1'b0; repeat (25) step(); btn = 1'b1; spent += 25;
    repeat (30) step(); spent += 30;
    btn = 1'b0; repeat (25) step(); btn = 1'b1; spent += 25;
    repeat (30) step(); spent += 30;
    check("mode_held_in_run", 32'(mode), 32'd1);
    core_finish(spent, 500, 8'h3C);
    check("show_busy", 32'(busy), 32'd0);
    check("show_no_start", 32'(core_start), 32'd0);
    check("show_led", 32'(led), 32'h3C);
    step();
    check("restart_start", 32'(core_start), 32'd1);
    check("restart_mode", 32'(mode), 32'd2);

    // Core never answers: watchdog
    k = 0;
    while (busy === 1'b1 && k < 5000) begin step(); k++; end
    check("timeout_edge", 32'(k), 32'd4097);
    check("timeout_led", 32'(led), 32'(LED_ERROR));
    s0 = n_starts;
    repeat (10) step();
    check("timeout_sits_show", 32'(n_starts - s0), 32'd0);
    check("timeout_busy", 32'(busy), 32'd0);

    // Done coincident with watchdog expiry: done wins
    press_to_start(25, k, spent);
    check("mode_run3", 32'(mode), 32'd3);
    val = 8'h5A ^ LED_W'($urandom_range(0, 127));
    core_finish(spent, 4096, val);
    check("coincident_led", 32'(led), 32'(val));
    check("coincident_busy", 32'(busy), 32'd0);
    repeat (30) step();

    // Asynchronous reset in the middle of a run
    press_to_start(25, k, spent);
    check("mode_run4", 32'(mode), 32'd4);
    repeat (50) step();
    rst_n = 1'b0;
    #1;
    check("rst_mode", 32'(mode), 32'(MODE_QSIM));
    check("rst_start", 32'(core_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    step(); step();
    rst_n = 1'b1;
    wait_start(40, k);
    check("restart_after_rst_edge", 32'(k), 32'd20);
    check("restart_after_rst_mode", 32'(mode), 32'(MODE_QSIM));
    val = LED_W'($urandom);
    core_finish(0, int'($urandom_range(5, 100)), val);
    check("led_after_rst", 32'(led), 32'(val));

    // Randomized button activity and core latencies, including stray done pulses
    done_in = 0;
    btn_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (btn_left == 0) begin
        btn = ~btn;
        btn_left = int'($urandom_range(1, 45));
      end
      btn_left--;
      core_done = 1'b0;
      if (core_start === 1'b1) begin
        done_in = int'($urandom_range(1, 200));
      end else if (done_in > 0) begin
        done_in--;
        if (done_in == 0) begin
          core_done = 1'b1;
          core_result = LED_W'($urandom);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        core_done = 1'b1;
        core_result = LED_W'($urandom);
      end
      step();
    end
    btn = 1'b1;
    core_done = 1'b0;
    repeat (5) step();

    check("mode_stable_in_run", 32'(n_mode_chg), 32'd0);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_mode_ctrl.md
# button_mode_ctrl

Front-end control stage for the FPGA top level. It debounces the active-low WF_BUTTON and steps a 4-bit demo mode, wrapping 15→0. It auto-starts the compute core after reset, runs a start/done handshake with that core, and latches the core's 8-bit result onto WF_LED. It sits between the board pins and the mode-indexed compute core, replacing ad-hoc reset-counter and debounce logic in the top level.

## Interface
- DEBOUNCE_CYCLES, 20: consecutive stable synchronized samples required to accept a level change.
- RESET_MODE, 14: mode after reset.
- AUTOSTART_DELAY, 20: cycles from reset release to the first start.
- TIMEOUT_CYCLES, 4096: maximum cycles spent in RUN before abort.
- RESULT_W, 8: result and LED width.
- Ports:
  - WF_CLK  in  1  system clock, 12 MHz.
  - rst_n  in  1  asynchronous, active-low reset.
  - WF_BUTTON  in  1  raw pushbutton, active low, asynchronous to WF_CLK.
  - mode  out  4  current mode index to the core.
  - core_start  out  1  one-cycle start pulse.
  - core_done  in  1  one-cycle completion pulse from the core.
  - core_result  in  RESULT_W  result, valid in the core_done cycle.
  - WF_LED  out  RESULT_W  latched result or error pattern.
  - busy  out  1  high in START or RUN.

## Operation
- Synchronizer: 2 flops, reset value 1 (unpressed).
- Debounce:
  - A counter runs while the synchronized level differs from `stable`, and clears whenever the two agree.
  - When the counter reaches DEBOUNCE_CYCLES, `stable` takes the synchronized level and the counter clears.
  - `press_evt` is a registered one-cycle pulse on a `stable` 1→0 transition. Release generates no event.
- FSM states WAIT, START, RUN, SHOW; reset state is WAIT.
  - WAIT: count AUTOSTART_DELAY cycles, then go to START.
  - START: core_start=1 for exactly one cycle, load the watchdog, go to RUN.
  - RUN: on core_done, set WF_LED ← core_result and go to SHOW. If the watchdog expires, set WF_LED ← all ones and go to SHOW. core_done seen outside RUN is ignored.
  - SHOW: on `press_evt` or `pending`, set mode ← mode+1 (mod 16), clear `pending`, and go to START.
- `pending`:
  - One-deep flag, set by any `press_evt` in WAIT, START or RUN.
  - Multiple presses collapse into one pending press.
  - In WAIT, `pending` does not shorten the delay. After the first run completes, SHOW consumes it.
- mode changes only on the SHOW→START edge, so it is stable from START through the end of RUN.
- Reset values:
  - mode = RESET_MODE
  - WF_LED = 0
  - core_start = 0
  - busy = 0
  - `pending` = 0
  - `stable` = 1
- Reset mid-RUN aborts immediately. The core must tolerate losing its requester; no completion is waited for.

## Timing
- Button low first sampled at edge 0. `stable` falls at edge DEBOUNCE_CYCLES+1. `press_evt` is high during the cycle after edge DEBOUNCE_CYCLES+2.
- SHOW → START on the edge that samples `press_evt`. core_start is high for the following cycle and mode is already updated in that cycle.
- First core_start is high in cycle AUTOSTART_DELAY+1 after rst_n deasserts (counted in rising edges).
- core_done → WF_LED update: 1 edge. WF_LED is registered and holds until the next completion or timeout.
- core_done and watchdog expiry in the same cycle: done wins and the result is latched.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.

## Structure
- Shared package `qos_fpga_pkg` holds:
  - FSM state enum
  - MODE_W=4, MODE_GOLDEN=0, MODE_QSIM=14, MODE_ROUNDTRIP=15
  - LED_ERROR = all ones
- Sub-module `btn_debounce` contains the synchronizer, debounce counter and press edge detector, parameterised by DEBOUNCE_CYCLES. The FSM, watchdog and LED latch stay in `button_mode_ctrl`.
- Target size: about 200 RTL lines.

## Test plan
- Reset release → single core_start at cycle 21 with mode=14. Core returns 8'hA5 after 64 cycles → WF_LED=8'hA5, busy=0.
- Press held 30 cycles in SHOW → exactly one press_evt; mode 14→15 and a second core_start. A subsequent press takes mode 15→0 (wrap).
- 15-cycle button glitch, plus a bouncing pattern that toggles every 5 cycles for 100 cycles → no mode change, no core_start.
- Two presses during a 500-cycle RUN → after core_done, exactly one increment and an immediate restart in the next cycle. mode is held constant throughout RUN.
- Core never asserts done → after TIMEOUT_CYCLES, WF_LED=8'hFF and the FSM sits in SHOW. core_done coincident with expiry latches core_result.
- rst_n pulsed low mid-RUN → all outputs at reset values asynchronously, mode=14, and the autostart sequence repeats.
